// File: rtl/operand_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_pkg
// Purpose  : Shared CPU datapath widths, types and the operand-select helper
//            used by operand fetch and the register file.
// Revision : 1.0 - initial release
// ============================================================================
package operand_fetch_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 1 << ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  // Register 0 is hard zero; a writeback landing this cycle beats the
  // (stale) register-file read.
  function automatic data_t select_operand(
    input addr_t addr,
    input data_t rf_data,
    input logic  wb_valid,
    input addr_t wb_addr,
    input data_t wb_data
  );
    data_t result;
    if (addr == '0) begin
      result = '0;
    end else if (wb_valid && (wb_addr == addr)) begin
      result = wb_data;
    end else begin
      result = rf_data;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/operand_fetch_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : scoreboard
// Purpose  : Per-register pending-write tracker. One set port, a writeback
//            clear port, a flush clear port, two source lookups and one
//            destination lookup. Lookups ignore bits being cleared this cycle.
// Revision : 1.0 - initial release
// ============================================================================
module scoreboard
  import operand_fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_set_en,
  input  addr_t i_set_addr,
  input  logic  i_clr_en,
  input  addr_t i_clr_addr,
  input  logic  i_fclr_en,
  input  addr_t i_fclr_addr,
  input  addr_t i_src1_addr,
  input  addr_t i_src2_addr,
  input  addr_t i_dst_addr,
  output logic  o_src1_busy,
  output logic  o_src2_busy,
  output logic  o_dst_busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Clears apply first, then the set, so a same-cycle set wins
  always_comb begin
    w_clr_mask = '0;
    w_busy_nxt = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_clr_mask[i] = (i_clr_en  && (i_clr_addr  == addr_t'(i))) ||
                      (i_fclr_en && (i_fclr_addr == addr_t'(i)));
      w_busy_nxt[i] = r_busy[i] && !w_clr_mask[i];
      if (i_set_en && (i_set_addr == addr_t'(i))) begin
        w_busy_nxt[i] = 1'b1;
      end
    end
  end

  // Scoreboard state; bit 0 never leaves zero since w_busy_nxt[0] is 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_src1_busy = r_busy[i_src1_addr] && !w_clr_mask[i_src1_addr];
  assign o_src2_busy = r_busy[i_src2_addr] && !w_clr_mask[i_src2_addr];
  assign o_dst_busy  = r_busy[i_dst_addr]  && !w_clr_mask[i_dst_addr];

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Purpose  : Issue-stage operand fetch with RAW/WAW scoreboard interlock,
//            same-cycle writeback bypass, one-entry output register with
//            valid/ready backpressure and flush.
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int PAYLOAD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_raddr1,
  input  logic [4:0]           in_raddr2,
  input  logic [4:0]           in_waddr,
  input  logic                 in_wen,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic [4:0]           rf_raddr1,
  output logic [4:0]           rf_raddr2,
  input  logic [31:0]          rf_rdata1,
  input  logic [31:0]          rf_rdata2,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_waddr,
  input  logic [31:0]          wb_wdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_op1,
  output logic [31:0]          out_op2,
  output logic [4:0]           out_waddr,
  output logic                 out_wen,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 flush
);

  logic w_src1_busy;
  logic w_src2_busy;
  logic w_dst_busy;
  logic w_hazard;
  logic w_accept;
  logic w_flush_clr;

  assign rf_raddr1 = in_raddr1;
  assign rf_raddr2 = in_raddr2;

  assign w_hazard = in_valid && (w_src1_busy || w_src2_busy || (in_wen && w_dst_busy));

  // in_ready is forced low during reset so nothing is accepted then
  assign in_ready = rst_n && (!out_valid || out_ready) && !w_hazard && !flush;
  assign w_accept = in_valid && in_ready;

  // Only the entry still held at the output may release its destination
  assign w_flush_clr = flush && out_valid && out_wen;

  scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_set_en    (w_accept && in_wen),
    .i_set_addr  (in_waddr),
    .i_clr_en    (wb_valid),
    .i_clr_addr  (wb_waddr),
    .i_fclr_en   (w_flush_clr),
    .i_fclr_addr (out_waddr),
    .i_src1_addr (in_raddr1),
    .i_src2_addr (in_raddr2),
    .i_dst_addr  (in_waddr),
    .o_src1_busy (w_src1_busy),
    .o_src2_busy (w_src2_busy),
    .o_dst_busy  (w_dst_busy)
  );

  // Output entry: flush drops it, accept refills it, drain empties it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_waddr   <= '0;
      out_wen     <= 1'b0;
      out_payload <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (w_accept) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (w_accept) begin
        out_op1     <= select_operand(in_raddr1, rf_rdata1, wb_valid, wb_waddr, wb_wdata);
        out_op2     <= select_operand(in_raddr2, rf_rdata2, wb_valid, wb_waddr, wb_wdata);
        out_waddr   <= in_waddr;
        out_wen     <= in_wen;
        out_payload <= in_payload;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_fetch
// Purpose  : Self-checking bench for operand_fetch: directed scenarios plus
//            randomized traffic against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

  localparam int PW = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_raddr1;
  logic [4:0]    in_raddr2;
  logic [4:0]    in_waddr;
  logic          in_wen;
  logic [PW-1:0] in_payload;
  logic [4:0]    rf_raddr1;
  logic [4:0]    rf_raddr2;
  logic [31:0]   rf_rdata1;
  logic [31:0]   rf_rdata2;
  logic          wb_valid;
  logic [4:0]    wb_waddr;
  logic [31:0]   wb_wdata;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_op1;
  logic [31:0]   out_op2;
  logic [4:0]    out_waddr;
  logic          out_wen;
  logic [PW-1:0] out_payload;
  logic          flush;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0]   m_busy;
  logic          m_valid;
  logic [31:0]   m_op1;
  logic [31:0]   m_op2;
  logic [4:0]    m_waddr;
  logic          m_wen;
  logic [PW-1:0] m_payload;

  always #5 clk = ~clk;

  operand_fetch #(.PAYLOAD_W(PW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_raddr1   (in_raddr1),
    .in_raddr2   (in_raddr2),
    .in_waddr    (in_waddr),
    .in_wen      (in_wen),
    .in_payload  (in_payload),
    .rf_raddr1   (rf_raddr1),
    .rf_raddr2   (rf_raddr2),
    .rf_rdata1   (rf_rdata1),
    .rf_rdata2   (rf_rdata2),
    .wb_valid    (wb_valid),
    .wb_waddr    (wb_waddr),
    .wb_wdata    (wb_wdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op1     (out_op1),
    .out_op2     (out_op2),
    .out_waddr   (out_waddr),
    .out_wen     (out_wen),
    .out_payload (out_payload),
    .flush       (flush)
  );

  function automatic logic [31:0] dut_busy();
    return dut.u_scoreboard.r_busy;
  endfunction

  // A register blocks issue if it has a pending write not retiring now
  function automatic logic pending(input logic [4:0] r);
    logic retiring;
    retiring = (wb_valid && wb_waddr == r) ||
               (flush && m_valid && m_wen && m_waddr == r);
    return (r != 5'd0) && m_busy[r] && !retiring;
  endfunction

  function automatic logic exp_ready();
    logic hz;
    hz = in_valid && (pending(in_raddr1) || pending(in_raddr2) ||
                      (in_wen && pending(in_waddr)));
    return rst_n && (!m_valid || out_ready) && !hz && !flush;
  endfunction

  function automatic logic [31:0] exp_operand(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'd0;
    if (wb_valid && wb_waddr == a) return wb_wdata;
    return rf;
  endfunction

  task automatic model_reset();
    m_busy = '0; m_valid = 1'b0; m_op1 = '0; m_op2 = '0;
    m_waddr = '0; m_wen = 1'b0; m_payload = '0;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_raddr1 = '0; in_raddr2 = '0; in_waddr = '0;
    in_wen = 1'b0; in_payload = '0; rf_rdata1 = '0; rf_rdata2 = '0;
    wb_valid = 1'b0; wb_waddr = '0; wb_wdata = '0; out_ready = 1'b0; flush = 1'b0;
  endtask

  // Advance one clock: update the model from the current inputs, then
  // land at posedge+1 where registered outputs are stable.
  task automatic tick();
    logic        acc;
    logic [31:0] nb;
    acc = in_valid && exp_ready();
    nb  = m_busy;
    if (wb_valid) nb[wb_waddr] = 1'b0;
    if (flush && m_valid && m_wen) nb[m_waddr] = 1'b0;
    if (acc && in_wen) nb[in_waddr] = 1'b1;
    nb[0] = 1'b0;
    if (flush) begin
      m_valid = 1'b0;
    end else if (acc) begin
      m_valid   = 1'b1;
      m_op1     = exp_operand(in_raddr1, rf_rdata1);
      m_op2     = exp_operand(in_raddr2, rf_rdata2);
      m_waddr   = in_waddr;
      m_wen     = in_wen;
      m_payload = in_payload;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    m_busy = nb;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    in_valid = 1'b1;
    out_ready = 1'b1;
    model_reset();
    #12;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if ({out_op1, out_op2, out_waddr, out_wen, out_payload} !== '0) begin
      failures++; $display("FAIL reset_out_fields op1=%h op2=%h waddr=%0d wen=%b payload=%h exp=all zero",
                           out_op1, out_op2, out_waddr, out_wen, out_payload);
    end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++;
    if (dut_busy() !== 32'd0) begin failures++; $display("FAIL reset_busy got=%h exp=0", dut_busy()); end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_bypass();
    do_reset();
    in_valid = 1'b1; in_raddr1 = 5'd1; in_raddr2 = 5'd2; in_waddr = 5'd3; in_wen = 1'b1;
    rf_rdata1 = $urandom; rf_rdata2 = $urandom; out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bypass_first_accept in_ready=%b exp=1", in_ready); end
    tick();
    in_raddr1 = 5'd3; in_raddr2 = 5'd0; in_waddr = 5'd0; in_wen = 1'b0;
    rf_rdata1 = 32'hDEAD_BEEF; out_ready = 1'b1;
    wb_valid = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h0000_1234;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bypass_accept in_ready=%b exp=1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_op1 !== 32'h0000_1234) begin
      failures++; $display("FAIL bypass_op1 valid=%b op1=%h exp valid=1 op1=00001234", out_valid, out_op1);
    end
    checks++;
    if (dut_busy() !== 32'd0) begin failures++; $display("FAIL bypass_busy got=%h exp=0", dut_busy()); end
    idle_inputs();
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_raw_stall();
    logic [31:0] w;
    do_reset();
    in_valid = 1'b1; in_waddr = 5'd5; in_wen = 1'b1; out_ready = 1'b1;
    tick();
    in_waddr = 5'd0; in_wen = 1'b0; in_raddr2 = 5'd5; in_raddr1 = 5'd0;
    for (int k = 0; k < 3; k++) begin
      rf_rdata2 = $urandom;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL raw_stall_cycle%0d in_ready=%b exp=0", k, in_ready); end
      tick();
    end
    w = $urandom;
    wb_valid = 1'b1; wb_waddr = 5'd5; wb_wdata = w; rf_rdata2 = ~w;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL raw_release in_ready=%b exp=1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_op2 !== w) begin
      failures++; $display("FAIL raw_op2 valid=%b op2=%h exp valid=1 op2=%h", out_valid, out_op2, w);
    end
    idle_inputs();
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_waw_set_wins();
    do_reset();
    in_valid = 1'b1; in_waddr = 5'd7; in_wen = 1'b1; out_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL waw_stall in_ready=%b exp=0", in_ready); end
    wb_valid = 1'b1; wb_waddr = 5'd7; wb_wdata = $urandom;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL waw_accept in_ready=%b exp=1", in_ready); end
    tick();
    checks++;
    if (dut_busy() !== 32'h0000_0080) begin failures++; $display("FAIL waw_set_wins busy=%h exp=00000080", dut_busy()); end
    idle_inputs();
    out_ready = 1'b1;
    wb_valid = 1'b1; wb_waddr = 5'd7;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_reg0();
    do_reset();
    in_valid = 1'b1; in_raddr1 = 5'd0; in_raddr2 = 5'd0; in_waddr = 5'd0; in_wen = 1'b1;
    rf_rdata1 = 32'hFFFF_FFFF; rf_rdata2 = 32'hFFFF_FFFF;
    wb_valid = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'h0000_00AA; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_op1 !== 32'd0 || out_op2 !== 32'd0) begin
      failures++; $display("FAIL reg0_operand valid=%b op1=%h op2=%h exp valid=1 op1=0 op2=0", out_valid, out_op1, out_op2);
    end
    checks++;
    if (dut_busy() !== 32'd0) begin failures++; $display("FAIL reg0_busy got=%h exp=0", dut_busy()); end
    idle_inputs();
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_backpressure_flush();
    logic [31:0]   e1;
    logic [31:0]   e2;
    logic [PW-1:0] pl;
    do_reset();
    e1 = $urandom; e2 = $urandom; pl = PW'($urandom);
    in_valid = 1'b1; in_raddr1 = 5'd4; in_raddr2 = 5'd6; in_waddr = 5'd9; in_wen = 1'b1;
    in_payload = pl; rf_rdata1 = e1; rf_rdata2 = e2; out_ready = 1'b0;
    tick();
    in_raddr1 = 5'd1; in_raddr2 = 5'd2; in_waddr = 5'd10; in_wen = 1'b0; in_payload = ~pl;
    for (int k = 0; k < 3; k++) begin
      rf_rdata1 = $urandom; rf_rdata2 = $urandom;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_cycle%0d got=%b exp=0", k, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_op1 !== e1 || out_op2 !== e2 || out_waddr !== 5'd9 ||
          out_wen !== 1'b1 || out_payload !== pl) begin
        failures++;
        $display("FAIL bp_hold_cycle%0d got v=%b op1=%h op2=%h wa=%0d wen=%b pl=%h exp v=1 op1=%h op2=%h wa=9 wen=1 pl=%h",
                 k, out_valid, out_op1, out_op2, out_waddr, out_wen, out_payload, e1, e2, pl);
      end
    end
    flush = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (dut_busy() !== 32'd0) begin failures++; $display("FAIL flush_busy9 busy=%h exp=0", dut_busy()); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1; in_waddr = 5'd11; in_wen = 1'b1; out_ready = 1'b0;
    tick();
    in_waddr = 5'd0; in_wen = 1'b0; in_raddr1 = 5'd11;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL areset_stall in_ready=%b exp=0", in_ready); end
    tick();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || dut_busy() !== 32'd0) begin
      failures++; $display("FAIL areset_immediate valid=%b busy=%h exp valid=0 busy=0", out_valid, dut_busy());
    end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL areset_in_ready got=%b exp=0", in_ready); end
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_raddr1  = 5'($urandom_range(0, 7));
      in_raddr2  = 5'($urandom_range(0, 7));
      in_waddr   = 5'($urandom_range(0, 7));
      in_wen     = 1'($urandom_range(0, 1));
      in_payload = PW'($urandom);
      rf_rdata1  = $urandom;
      rf_rdata2  = $urandom;
      wb_valid   = ($urandom_range(0, 2) == 0);
      wb_waddr   = 5'($urandom_range(0, 7));
      wb_wdata   = $urandom;
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      #1;
      checks++;
      if (in_ready !== exp_ready()) begin
        failures++; $display("FAIL rand_in_ready n=%0d got=%b exp=%b", n, in_ready, exp_ready());
      end
      checks++;
      if (rf_raddr1 !== in_raddr1 || rf_raddr2 !== in_raddr2) begin
        failures++; $display("FAIL rand_rf_raddr n=%0d got=%0d/%0d exp=%0d/%0d", n, rf_raddr1, rf_raddr2, in_raddr1, in_raddr2);
      end
      tick();
      checks++;
      if (out_valid !== m_valid || out_op1 !== m_op1 || out_op2 !== m_op2 ||
          out_waddr !== m_waddr || out_wen !== m_wen || out_payload !== m_payload) begin
        failures++;
        $display("FAIL rand_out n=%0d got v=%b op1=%h op2=%h wa=%0d wen=%b pl=%h exp v=%b op1=%h op2=%h wa=%0d wen=%b pl=%h",
                 n, out_valid, out_op1, out_op2, out_waddr, out_wen, out_payload,
                 m_valid, m_op1, m_op2, m_waddr, m_wen, m_payload);
      end
      checks++;
      if (dut_busy() !== m_busy) begin
        failures++; $display("FAIL rand_busy n=%0d got=%h exp=%h", n, dut_busy(), m_busy);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_bypass();
    test_raw_stall();
    test_waw_set_wins();
    test_reg0();
    test_backpressure_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
